clk_pattern_ctrl: RTL and testbench
===================================

CLK_PATTERN_CTRL -- requirements
Module: clk_pattern_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the phase counters and config fields.
REQ-002 SHALL have parameter JIT_W, default 4, giving the width of the jitter mask (used only with CLKPAT_JITTER_EN).
REQ-003 SHALL have ports as follows.
- CLK  in  1  single clock; all logic rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = generate pattern, 0 = stop.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  shadow register free.
- cfg_offset  in  CNT_W  cycles from start to first rising edge.
- cfg_high  in  CNT_W  high-phase length in cycles.
- cfg_low  in  CNT_W  low-phase length in cycles.
- clk_out  out  1  registered generated waveform.
- edge_rise  out  1  1-cycle pulse in the first HIGH cycle.
- edge_fall  out  1  1-cycle pulse in the first LOW cycle.
- busy  out  1  state != IDLE.
- cfg_err  out  1  1-cycle pulse on rejected config.
- cfg_jit_mask  in  JIT_W  jitter mask; present only with CLKPAT_JITTER_EN.

Function
REQ-004 SHALL implement FSM states IDLE, OFFSET, HIGH, LOW; clk_out=1 only in HIGH.
REQ-005 SHALL accept config on cfg_valid&&cfg_ready into a shadow register, setting pending, with cfg_ready = !pending.
REQ-006 SHALL reject config with cfg_high==0 or cfg_low==0: handshake completes, shadow unchanged, cfg_err pulses the next cycle.
REQ-007 SHALL copy shadow to the active config and clear pending when in IDLE, or in the last LOW cycle (period boundary); never mid-period.
REQ-008 SHALL, if a config is accepted in the same cycle as a boundary, apply it at the next boundary, not the current one.
REQ-009 SHALL, on run=1 in IDLE with a valid active config, enter OFFSET for cfg_offset cycles, or go directly to HIGH when cfg_offset==0.
REQ-010 SHALL hold HIGH exactly cfg_high cycles and LOW exactly cfg_low cycles, period = high+low cycles.
REQ-011 SHALL ignore run=1 when no valid active config exists since reset (stays IDLE).
REQ-012 SHALL, on run=0, return from OFFSET to IDLE immediately; from HIGH or LOW, complete the current period through the end of LOW, then go to IDLE (no runt pulses).
REQ-013 SHALL, when run re-asserts in the final LOW cycle, continue to HIGH without passing through IDLE or OFFSET.
REQ-014 SHALL use saturating-free down-counters; counts equal to 2^CNT_W-1 are legal.

Reset
REQ-015 SHALL on RST_N=0: state=IDLE, clk_out=0, edge_rise=0, edge_fall=0, busy=0, cfg_err=0, cfg_ready=1, pending=0, active config invalid, LFSR=16'hACE1.
REQ-016 SHALL, when reset asserts mid-period, drive clk_out low asynchronously.

Configuration
REQ-017 SHALL, with CLKPAT_JITTER_EN defined, advance a 16-bit LFSR at every phase start and extend each HIGH/LOW phase by (lfsr[JIT_W-1:0] & cfg_jit_mask) cycles.
REQ-018 SHALL, without CLKPAT_JITTER_EN, omit the cfg_jit_mask port and the LFSR, with phase lengths exactly as programmed.

Structure
REQ-019 SHALL place the FSM state encoding, the LFSR seed and the LFSR taps (x^16+x^14+x^13+x^11+1) in shared package clk_pattern_pkg.
REQ-020 SHALL put the phase down-counter with load/zero-detect in sub-module clk_pattern_cnt.

Verification
REQ-021 SHALL cover: cfg offset=3, high=2, low=4, run=1 -> first rise 3 cycles after start, then period 6, duty 2/6.
REQ-022 SHALL cover: cfg high=0 -> cfg_err pulse, shadow untouched, output pattern unchanged.
REQ-023 SHALL cover: new cfg high=5, low=5 accepted mid-HIGH -> old period completes, and the next period is 10 cycles.
REQ-024 SHALL cover: run dropped in HIGH phase 1 of 2 -> HIGH completes, full LOW completes, then IDLE with busy=0.
REQ-025 SHALL cover: RST_N pulled low mid-HIGH -> clk_out=0 immediately, cfg_ready=1, and run is ignored until reconfigured.
REQ-026 SHALL cover: with CLKPAT_JITTER_EN and mask=0 -> waveform identical to the build without the macro; with mask=4'hF -> every phase length lies within [programmed, programmed+15].

Source files
------------

// File: rtl/clk_pattern_pkg.sv
// Shared definitions for the programmable clock-pattern generator:
// FSM state encoding, jitter LFSR seed/taps and the LFSR step function.
package clk_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFSET = 2'd1,
    HIGH   = 2'd2,
    LOW    = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/clk_pattern_cnt.sv
// Phase down-counter: loads (length-1) at phase entry, counts down to zero
// and holds there; zero marks the last cycle of the current phase.
module clk_pattern_cnt #(
  parameter int unsigned W = 17
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load on phase entry, otherwise count down and stop at zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/clk_pattern_ctrl.sv
// Programmable clock-pattern generator: optional start offset, then a
// repeating HIGH/LOW waveform with double-buffered configuration that only
// takes effect at period boundaries.
// Optional feature macro: CLKPAT_JITTER_EN (LFSR-driven phase extension,
// adds the cfg_jit_mask port).
module clk_pattern_ctrl
  import clk_pattern_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned JIT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_offset,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             clk_out,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic             busy,
  output logic             cfg_err
`ifdef CLKPAT_JITTER_EN
  ,
  input  logic [JIT_W-1:0] cfg_jit_mask
`endif
);

  // One extra bit so programmed length plus jitter extension never wraps
  localparam int unsigned PW = ((CNT_W > JIT_W) ? CNT_W : JIT_W) + 1;

  state_t state, next_state;

  logic [CNT_W-1:0] shd_offset, shd_high, shd_low;
  logic [CNT_W-1:0] act_offset, act_high, act_low;
  logic [CNT_W-1:0] use_offset, use_high, use_low;
  logic             pending, act_valid, use_valid;
  logic             accept, cfg_bad, apply;
  logic             cnt_zero, load;
  logic [PW-1:0]    load_val, jit_ext;

  assign cfg_ready = !pending;
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_high == '0) || (cfg_low == '0);

  // Shadow is promoted in IDLE or in the last LOW cycle; a config accepted
  // in that same cycle is not yet pending, so it waits for the next boundary.
  assign apply = pending && ((state == IDLE) || ((state == LOW) && cnt_zero));

  // The phase entered on a boundary must already see the promoted values.
  assign use_offset = apply ? shd_offset : act_offset;
  assign use_high   = apply ? shd_high   : act_high;
  assign use_low    = apply ? shd_low    : act_low;
  assign use_valid  = act_valid || apply;

`ifdef CLKPAT_JITTER_EN
  logic [15:0] lfsr;
  logic        phase_start;

  assign phase_start = load && ((next_state == HIGH) || (next_state == LOW));
  assign jit_ext     = PW'(lfsr[JIT_W-1:0] & cfg_jit_mask);

  // Advance the jitter LFSR once per HIGH/LOW phase start
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr <= LFSR_SEED;
    end else if (phase_start) begin
      lfsr <= lfsr_next(lfsr);
    end
  end
`else
  assign jit_ext = '0;
`endif

  // Config handshake, shadow/active double buffer and reject pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shd_offset <= '0;
      shd_high   <= '0;
      shd_low    <= '0;
      act_offset <= '0;
      act_high   <= '0;
      act_low    <= '0;
      pending    <= 1'b0;
      act_valid  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= accept && cfg_bad;
      if (accept && !cfg_bad) begin
        shd_offset <= cfg_offset;
        shd_high   <= cfg_high;
        shd_low    <= cfg_low;
        pending    <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (apply) begin
        act_offset <= shd_offset;
        act_high   <= shd_high;
        act_low    <= shd_low;
        act_valid  <= 1'b1;
      end
    end
  end

  // Next-state logic and phase counter reload value
  always_comb begin
    next_state = state;
    load_val   = '0;
    case (state)
      IDLE: begin
        if (run && use_valid) begin
          next_state = (use_offset == '0) ? HIGH : OFFSET;
        end
      end
      OFFSET: begin
        if (!run) begin
          next_state = IDLE;
        end else if (cnt_zero) begin
          next_state = HIGH;
        end
      end
      HIGH: begin
        if (cnt_zero) begin
          next_state = LOW;
        end
      end
      LOW: begin
        if (cnt_zero) begin
          next_state = run ? HIGH : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    load = (next_state != state);
    case (next_state)
      OFFSET:  load_val = PW'(use_offset) - PW'(1);
      HIGH:    load_val = PW'(use_high) - PW'(1) + jit_ext;
      LOW:     load_val = PW'(use_low) - PW'(1) + jit_ext;
      default: load_val = '0;
    endcase
  end

  // State register and registered waveform/status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      clk_out   <= 1'b0;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      clk_out   <= (next_state == HIGH);
      edge_rise <= (next_state == HIGH) && (state != HIGH);
      edge_fall <= (next_state == LOW) && (state != LOW);
      busy      <= (next_state != IDLE);
    end
  end

  clk_pattern_cnt #(
    .W(PW)
  ) u_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (load),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_clk_pattern_ctrl.sv
// Directed self-checking bench for clk_pattern_ctrl (CNT_W=16, JIT_W=4).
// With CLKPAT_JITTER_EN defined the mask is held at 0 for the directed
// patterns, then a final section bounds jittered phase lengths.
module tb_clk_pattern_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        run;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_offset, cfg_high, cfg_low;
  logic        clk_out, edge_rise, edge_fall, busy, cfg_err;
`ifdef CLKPAT_JITTER_EN
  logic [3:0]  jit_mask;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 CLK = ~CLK;

  clk_pattern_ctrl #(
    .CNT_W(16),
    .JIT_W(4)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_offset (cfg_offset),
    .cfg_high   (cfg_high),
    .cfg_low    (cfg_low),
    .clk_out    (clk_out),
    .edge_rise  (edge_rise),
    .edge_fall  (edge_fall),
    .busy       (busy),
    .cfg_err    (cfg_err)
`ifdef CLKPAT_JITTER_EN
    ,
    .cfg_jit_mask (jit_mask)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One cycle: advance past the rising edge, then settle
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a config for exactly one cycle
  task automatic offer(input logic [15:0] o, input logic [15:0] h, input logic [15:0] l);
    cfg_offset = o;
    cfg_high   = h;
    cfg_low    = l;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  // Shift n cycles of outputs in, oldest sample ends up most significant
  task automatic capture(input int unsigned n, output logic [63:0] wc, output logic [63:0] wr,
                         output logic [63:0] wf, output logic [63:0] wb);
    wc = '0; wr = '0; wf = '0; wb = '0;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      wc = {wc[62:0], clk_out};
      wr = {wr[62:0], edge_rise};
      wf = {wf[62:0], edge_fall};
      wb = {wb[62:0], busy};
    end
  endtask

  initial begin
    logic [63:0] wc, wr, wf, wb;
    RST_N      = 1'b0;
    run        = 1'b0;
    cfg_valid  = 1'b0;
    cfg_offset = '0;
    cfg_high   = '0;
    cfg_low    = '0;
`ifdef CLKPAT_JITTER_EN
    jit_mask   = 4'h0;
`endif

    // Reset state
    #3;
    check("rst_clk_out",   64'(clk_out),   64'd0);
    check("rst_edge_rise", 64'(edge_rise), 64'd0);
    check("rst_edge_fall", 64'(edge_fall), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_cfg_err",   64'(cfg_err),   64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    tick();
    tick();
    RST_N = 1'b1;

    // run without any config is ignored
    run = 1'b1;
    tick(); tick(); tick();
    check("nocfg_busy", 64'(busy), 64'd0);
    run = 1'b0;

    // offset=3 high=2 low=4
    offer(16'd3, 16'd2, 16'd4);
    check("cfg_pending_ready", 64'(cfg_ready), 64'd0);
    tick();
    check("cfg_applied_ready", 64'(cfg_ready), 64'd1);
    run = 1'b1;
    capture(18, wc, wr, wf, wb);
    check("p1_clk",  wc, 64'b000110000110000110);
    check("p1_rise", wr, 64'b000100000100000100);
    check("p1_fall", wf, 64'b000001000001000001);

    // Rejected config (high=0) during LOW
    cfg_offset = 16'd1;
    cfg_high   = 16'd0;
    cfg_low    = 16'd7;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    check("rej_err_pulse", 64'(cfg_err),   64'd1);
    check("rej_ready",     64'(cfg_ready), 64'd1);
    tick();
    check("rej_err_clear", 64'(cfg_err),   64'd0);
    capture(12, wc, wr, wf, wb);
    check("rej_pattern", wc, 64'b011000011000);

    // New config high=5 low=5 accepted in the middle of HIGH
    tick(); tick();
    check("mid_high_first", 64'(edge_rise), 64'd1);
    offer(16'd0, 16'd5, 16'd5);
    check("mid_high_pending", 64'(clk_out & ~cfg_ready), 64'd1);
    capture(20, wc, wr, wf, wb);
    check("newcfg_pattern", wc, 64'b00001111100000111110);
    check("newcfg_ready",   64'(cfg_ready), 64'd1);

    // Back to high=2 low=4, then drop run in the first HIGH cycle
    offer(16'd3, 16'd2, 16'd4);
    tick(); tick(); tick(); tick();
    check("stop_rise", 64'(edge_rise), 64'd1);
    run = 1'b0;
    capture(8, wc, wr, wf, wb);
    check("stop_clk",  wc, 64'b10000000);
    check("stop_busy", wb, 64'b11111000);
    check("stop_fall", wf, 64'b01000000);

    // run dropped during OFFSET aborts at once
    run = 1'b1;
    tick();
    check("offs_busy", 64'({busy, clk_out}), 64'b10);
    run = 1'b0;
    tick();
    check("offs_abort", 64'(busy), 64'd0);

    // offset=0 high=1 low=1 goes straight to HIGH
    offer(16'd0, 16'd1, 16'd1);
    tick();
    run = 1'b1;
    capture(5, wc, wr, wf, wb);
    check("min_clk",  wc, 64'b10101);
    check("min_rise", wr, 64'b10101);
    run = 1'b0;
    tick();
    check("relow_busy", 64'({busy, clk_out}), 64'b10);
    run = 1'b1;                       // re-assert in final LOW cycle
    tick();
    check("rerun_high", 64'({clk_out, edge_rise}), 64'b11);
    run = 1'b0;
    tick(); tick();
    check("rerun_idle", 64'(busy), 64'd0);

    // Reset mid-HIGH with a config pending
    run        = 1'b1;
    cfg_offset = 16'd2;
    cfg_high   = 16'd3;
    cfg_low    = 16'd3;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
    check("prerst_state", 64'({clk_out, cfg_ready}), 64'b10);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_async_clk",   64'(clk_out),   64'd0);
    check("rst_async_ready", 64'(cfg_ready), 64'd1);
    check("rst_async_busy",  64'(busy),      64'd0);
    tick();
    RST_N = 1'b1;
    tick(); tick(); tick();
    check("rst_run_ignored", 64'(busy), 64'd0);
    offer(16'd2, 16'd3, 16'd3);
    check("recfg_not_yet", 64'(busy), 64'd0);
    tick();
    check("recfg_start", 64'({busy, clk_out}), 64'b10);
    tick(); tick();
    check("recfg_rise", 64'({clk_out, edge_rise}), 64'b11);

`ifdef CLKPAT_JITTER_EN
    // Jittered phases must stay within [programmed, programmed+15]
    begin
      int unsigned len;
      int unsigned phases;
      logic        prev;
      run = 1'b0;
      for (int i = 0; i < 64 && busy; i++) tick();
      check("jit_idle", 64'(busy), 64'd0);
      jit_mask = 4'hF;
      offer(16'd0, 16'd3, 16'd3);
      tick();
      run    = 1'b1;
      tick();
      prev   = clk_out;
      len    = 1;
      phases = 0;
      for (int i = 0; i < 400 && phases < 16; i++) begin
        tick();
        if (clk_out == prev) begin
          len++;
        end else begin
          check("jit_len_range", 64'(len >= 3 && len <= 18), 64'd1);
          phases++;
          prev = clk_out;
          len  = 1;
        end
      end
      check("jit_phase_count", 64'(phases), 64'd16);
      run = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
